// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and defaults for the burst memory requester
package mem_if_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 5;

    // Cycles from a read strobe to mem_rdata being valid
    localparam int RD_LATENCY = 1;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/mem_requester_if.sv
// rtl/mem_requester_if.sv - core command/response and memory bus bundle
interface mem_requester_if
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              done;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requester side
    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wdata_valid, wdata, mem_rdata,
        output req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, done,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    // Core plus memory side
    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wdata_valid, wdata, mem_rdata,
        input  req_ready, wdata_ready, rsp_valid, rsp_data, rsp_last, done,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_rsp_pipe.sv
// rtl/mem_rsp_pipe.sv - read-response delay line and data capture register
module mem_rsp_pipe
    import mem_if_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = RD_LATENCY
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              issue,
    input  logic              issue_last,
    input  logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic              last,
    output logic [DATA_W-1:0] data
);

    // One extra stage beyond the memory latency for the capture register
    localparam int DEPTH = LATENCY + 1;

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] last_sr;

    // Shift the flags each cycle; grab rdata when the matching read's data is on the bus
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            valid_sr <= '0;
            last_sr  <= '0;
            data     <= '0;
        end else begin
            valid_sr <= {valid_sr[DEPTH-2:0], issue};
            last_sr  <= {last_sr[DEPTH-2:0], issue & issue_last};
            if (valid_sr[LATENCY-1]) begin
                data <= rdata;
            end
        end
    end

    assign valid = valid_sr[DEPTH-1];
    assign last  = last_sr[DEPTH-1];

endmodule

// File: rtl/mem_requester.sv
// rtl/mem_requester.sv - burst read/write sequencer for a single-port byte memory
module mem_requester
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic            clk,
    input  logic            rst_,
    mem_requester_if.master bus
);

    state_e            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  count;
    logic              wr_done;

    op_e               req_op;
    logic              rd_beat;
    logic              wr_beat;
    logic              last_beat;

    logic              pipe_valid;
    logic              pipe_last;
    logic [DATA_W-1:0] pipe_data;

    assign req_op    = op_e'(bus.req_write);
    assign rd_beat   = (state == RD);
    assign wr_beat   = (state == WR) && bus.wdata_valid;
    assign last_beat = (count == '0);

    // Burst sequencing: latch the command, then step address/count once per beat
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= IDLE;
            addr    <= '0;
            count   <= '0;
            wr_done <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr  <= bus.req_addr;
                        count <= bus.req_len;
                        state <= (req_op == OP_WRITE) ? WR : RD;
                    end
                end
                RD: begin
                    addr  <= addr + ADDR_W'(1);
                    count <= count - LEN_W'(1);
                    if (last_beat) begin
                        state <= DRAIN;
                    end
                end
                WR: begin
                    if (bus.wdata_valid) begin
                        addr  <= addr + ADDR_W'(1);
                        count <= count - LEN_W'(1);
                        if (last_beat) begin
                            state   <= IDLE;
                            wr_done <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_valid && pipe_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_rsp_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (RD_LATENCY)
    ) u_rsp_pipe (
        .clk        (clk),
        .rst_       (rst_),
        .issue      (rd_beat),
        .issue_last (last_beat),
        .rdata      (bus.mem_rdata),
        .valid      (pipe_valid),
        .last       (pipe_last),
        .data       (pipe_data)
    );

    // Strobes and address are decoded from state so a reset drops them immediately
    assign bus.req_ready   = (state == IDLE);
    assign bus.wdata_ready = (state == WR);
    assign bus.mem_read    = rd_beat;
    assign bus.mem_write   = wr_beat;
    assign bus.mem_addr    = (rd_beat || wr_beat) ? addr : '0;
    assign bus.mem_wdata   = wr_beat ? bus.wdata : '0;

    assign bus.rsp_valid   = pipe_valid;
    assign bus.rsp_last    = pipe_last;
    assign bus.rsp_data    = pipe_data;
    assign bus.done        = wr_done | ((state == DRAIN) && pipe_valid && pipe_last);

endmodule

// File: tb/tb_mem_requester.sv
// tb/tb_mem_requester.sv - directed self-checking bench for mem_requester
module tb_mem_requester;

    logic clk;
    logic rst_;

    int n_cmp;
    int n_err;

    logic [7:0] mem [0:31];

    logic       r_mrd  [0:47];
    logic       r_mwr  [0:47];
    logic [4:0] r_addr [0:47];
    logic [7:0] r_wd   [0:47];
    logic       r_rv   [0:47];
    logic [7:0] r_rd   [0:47];
    logic       r_rl   [0:47];
    logic       r_dn   [0:47];
    logic       r_rr   [0:47];
    logic       r_wrdy [0:47];

    mem_requester_if #(.ADDR_W(5), .DATA_W(8), .LEN_W(5)) bus ();

    mem_requester #(.ADDR_W(5), .DATA_W(8), .LEN_W(5)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fmem(input int i);
        return 8'(i * 13 + 5);
    endfunction

    // Byte memory with one-cycle registered read
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Protocol checks every cycle outside reset
    always @(negedge clk) begin
        if (rst_) begin
            n_cmp++;
            if (bus.mem_read && bus.mem_write) begin
                n_err++;
                $display("FAIL proto_strobes: mem_read=%b mem_write=%b want not both", bus.mem_read, bus.mem_write);
            end
            n_cmp++;
            if (bus.req_ready && (bus.mem_read || bus.mem_write || bus.rsp_valid)) begin
                n_err++;
                $display("FAIL proto_ready: req_ready=1 while busy (rd=%b wr=%b rv=%b) want 0", bus.mem_read, bus.mem_write, bus.rsp_valid);
            end
        end
    end

    task automatic run_read(input logic [4:0] a, input logic [4:0] l, input int ncyc);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_len = l;
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        r_rr[0] = bus.req_ready;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            r_mrd[k] = bus.mem_read;  r_addr[k] = bus.mem_addr; r_rv[k] = bus.rsp_valid;
            r_rd[k]  = bus.rsp_data;  r_rl[k]   = bus.rsp_last; r_dn[k] = bus.done;
            r_rr[k]  = bus.req_ready;
        end
    endtask

    task automatic run_write(input logic [4:0] a, input logic [4:0] l, input logic [7:0] vpat,
                             input logic [63:0] dats, input int ncyc);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_len = l;
        bus.wdata_valid = 1'b0;
        @(negedge clk);
        r_rr[0] = bus.req_ready; r_mwr[0] = bus.mem_write;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            bus.req_valid   = 1'b0;
            bus.wdata_valid = (k <= 8) ? vpat[k-1] : 1'b0;
            bus.wdata       = (k <= 8) ? dats[8*(k-1) +: 8] : 8'h00;
            @(negedge clk);
            r_mwr[k] = bus.mem_write; r_addr[k] = bus.mem_addr; r_wd[k] = bus.mem_wdata;
            r_dn[k]  = bus.done;      r_rr[k]   = bus.req_ready; r_wrdy[k] = bus.wdata_ready;
        end
        bus.wdata_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_ = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.wdata_ready !== 1'b0) begin n_err++; $display("FAIL reset_wdata_ready: got %b want 0", bus.wdata_ready); end
        n_cmp++; if ({bus.rsp_valid, bus.rsp_last, bus.done} !== 3'b000) begin n_err++; $display("FAIL reset_rsp_flags: got %b want 000", {bus.rsp_valid, bus.rsp_last, bus.done}); end
        n_cmp++; if (bus.rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data: got %h want 00", bus.rsp_data); end
        n_cmp++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {bus.mem_read, bus.mem_write}); end
        n_cmp++; if ({bus.mem_addr, bus.mem_wdata} !== 13'h0) begin n_err++; $display("FAIL reset_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
        @(posedge clk); #1;
        rst_ = 1'b1;
    endtask

    task automatic test_full_burst;
        run_read(5'd0, 5'd31, 36);
        n_cmp++; if (r_rr[0] !== 1'b1) begin n_err++; $display("FAIL full_ready_hs: got %b want 1", r_rr[0]); end
        for (int k = 1; k <= 36; k++) begin
            n_cmp++;
            if (r_mrd[k] !== (k <= 32)) begin n_err++; $display("FAIL full_mem_read k=%0d: got %b want %b", k, r_mrd[k], (k <= 32)); end
            if (k <= 32) begin
                n_cmp++;
                if (r_addr[k] !== 5'(k - 1)) begin n_err++; $display("FAIL full_addr k=%0d: got %0d want %0d", k, r_addr[k], k - 1); end
            end
            n_cmp++;
            if (r_rv[k] !== (k >= 3 && k <= 34)) begin n_err++; $display("FAIL full_rsp_valid k=%0d: got %b want %b", k, r_rv[k], (k >= 3 && k <= 34)); end
            if (k >= 3 && k <= 34) begin
                n_cmp++;
                if (r_rd[k] !== fmem(k - 3)) begin n_err++; $display("FAIL full_rsp_data k=%0d: got %h want %h", k, r_rd[k], fmem(k - 3)); end
            end
            n_cmp++;
            if ({r_rl[k], r_dn[k]} !== ((k == 34) ? 2'b11 : 2'b00)) begin n_err++; $display("FAIL full_last_done k=%0d: got %b want %b", k, {r_rl[k], r_dn[k]}, (k == 34) ? 2'b11 : 2'b00); end
            n_cmp++;
            if (r_rr[k] !== (k >= 35)) begin n_err++; $display("FAIL full_req_ready k=%0d: got %b want %b", k, r_rr[k], (k >= 35)); end
        end
    endtask

    task automatic test_read_latency;
        run_read(5'd10, 5'd0, 5);
        n_cmp++; if ({r_mrd[1], r_mrd[2], r_mrd[3]} !== 3'b100) begin n_err++; $display("FAIL lat_mem_read: got %b want 100", {r_mrd[1], r_mrd[2], r_mrd[3]}); end
        n_cmp++; if (r_addr[1] !== 5'd10) begin n_err++; $display("FAIL lat_addr: got %0d want 10", r_addr[1]); end
        n_cmp++; if ({r_rv[2], r_rv[3], r_rv[4]} !== 3'b010) begin n_err++; $display("FAIL lat_rsp_valid: got %b want 010", {r_rv[2], r_rv[3], r_rv[4]}); end
        n_cmp++; if ({r_rl[3], r_dn[3]} !== 2'b11) begin n_err++; $display("FAIL lat_last_done: got %b want 11", {r_rl[3], r_dn[3]}); end
        n_cmp++; if (r_dn[4] !== 1'b0) begin n_err++; $display("FAIL lat_done_pulse: got %b want 0", r_dn[4]); end
        n_cmp++; if (r_rd[3] !== fmem(10)) begin n_err++; $display("FAIL lat_rsp_data: got %h want %h", r_rd[3], fmem(10)); end
        n_cmp++; if ({r_rr[3], r_rr[4]} !== 2'b01) begin n_err++; $display("FAIL lat_req_ready: got %b want 01", {r_rr[3], r_rr[4]}); end
    endtask

    task automatic test_write_burst;
        logic [7:0] vals [0:3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        run_write(5'd3, 5'd3, 8'b0000_1111, 64'h0000_0000_4433_2211, 6);
        n_cmp++; if (r_mwr[0] !== 1'b0) begin n_err++; $display("FAIL wr_hs_no_access: got %b want 0", r_mwr[0]); end
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if ({r_mwr[k], r_addr[k], r_wd[k], r_dn[k]} !== {1'b1, 5'(k + 2), vals[k-1], 1'b0}) begin
                n_err++;
                $display("FAIL wr_beat k=%0d: got wr=%b addr=%0d data=%h done=%b want wr=1 addr=%0d data=%h done=0", k, r_mwr[k], r_addr[k], r_wd[k], r_dn[k], k + 2, vals[k-1]);
            end
        end
        n_cmp++; if ({r_mwr[5], r_dn[5], r_rr[5]} !== 3'b011) begin n_err++; $display("FAIL wr_done: got wr,done,ready=%b want 011", {r_mwr[5], r_dn[5], r_rr[5]}); end
        n_cmp++; if (r_dn[6] !== 1'b0) begin n_err++; $display("FAIL wr_done_pulse: got %b want 0", r_dn[6]); end
        run_read(5'd3, 5'd3, 8);
        for (int k = 3; k <= 7; k++) begin
            n_cmp++;
            if (k <= 6 && {r_rv[k], r_rd[k], r_rl[k]} !== {1'b1, vals[k-3], (k == 6)}) begin
                n_err++;
                $display("FAIL wr_readback k=%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, r_rv[k], r_rd[k], r_rl[k], vals[k-3], (k == 6));
            end else if (k == 7 && r_rv[k] !== 1'b0) begin
                n_err++;
                $display("FAIL wr_readback_end: got rsp_valid %b want 0", r_rv[k]);
            end
        end
    endtask

    task automatic test_wrap;
        run_write(5'd30, 5'd2, 8'b0000_0111, 64'h0000_0000_00A2_A1A0, 5);
        n_cmp++; if ({r_addr[1], r_addr[2], r_addr[3]} !== {5'd30, 5'd31, 5'd0}) begin n_err++; $display("FAIL wrap_wr_addr: got %0d,%0d,%0d want 30,31,0", r_addr[1], r_addr[2], r_addr[3]); end
        n_cmp++; if ({r_mwr[3], r_wd[3]} !== {1'b1, 8'hA2}) begin n_err++; $display("FAIL wrap_wr_data: got wr=%b d=%h want wr=1 d=a2", r_mwr[3], r_wd[3]); end
        n_cmp++; if (r_dn[4] !== 1'b1) begin n_err++; $display("FAIL wrap_done: got %b want 1", r_dn[4]); end
        run_read(5'd0, 5'd0, 4);
        n_cmp++; if ({r_rv[3], r_rd[3]} !== {1'b1, 8'hA2}) begin n_err++; $display("FAIL wrap_read0: got v=%b d=%h want v=1 d=a2", r_rv[3], r_rd[3]); end
        run_read(5'd31, 5'd1, 5);
        n_cmp++; if ({r_addr[1], r_addr[2]} !== {5'd31, 5'd0}) begin n_err++; $display("FAIL wrap_rd_addr: got %0d,%0d want 31,0", r_addr[1], r_addr[2]); end
        n_cmp++; if ({r_rd[3], r_rd[4], r_rl[3], r_rl[4], r_dn[4]} !== {8'hA1, 8'hA2, 1'b0, 1'b1, 1'b1}) begin n_err++; $display("FAIL wrap_rd_data: got %h,%h last=%b%b done=%b want a1,a2 last=01 done=1", r_rd[3], r_rd[4], r_rl[3], r_rl[4], r_dn[4]); end
    endtask

    task automatic test_write_stall;
        run_write(5'd12, 5'd1, 8'b0000_1001, 64'h0000_0000_6600_0055, 6);
        n_cmp++; if ({r_mwr[1], r_addr[1], r_wd[1]} !== {1'b1, 5'd12, 8'h55}) begin n_err++; $display("FAIL stall_beat0: got wr=%b a=%0d d=%h want wr=1 a=12 d=55", r_mwr[1], r_addr[1], r_wd[1]); end
        n_cmp++; if ({r_mwr[2], r_mwr[3], r_wrdy[2], r_wrdy[3]} !== 4'b0011) begin n_err++; $display("FAIL stall_idle: got wr=%b%b rdy=%b%b want wr=00 rdy=11", r_mwr[2], r_mwr[3], r_wrdy[2], r_wrdy[3]); end
        n_cmp++; if ({r_dn[2], r_dn[3], r_dn[4]} !== 3'b000) begin n_err++; $display("FAIL stall_early_done: got %b want 000", {r_dn[2], r_dn[3], r_dn[4]}); end
        n_cmp++; if ({r_mwr[4], r_addr[4], r_wd[4]} !== {1'b1, 5'd13, 8'h66}) begin n_err++; $display("FAIL stall_beat1: got wr=%b a=%0d d=%h want wr=1 a=13 d=66", r_mwr[4], r_addr[4], r_wd[4]); end
        n_cmp++; if ({r_dn[5], r_dn[6], r_wrdy[5]} !== 3'b100) begin n_err++; $display("FAIL stall_done: got done=%b%b rdy=%b want done=10 rdy=0", r_dn[5], r_dn[6], r_wrdy[5]); end
        run_read(5'd12, 5'd1, 5);
        n_cmp++; if ({r_rd[3], r_rd[4]} !== {8'h55, 8'h66}) begin n_err++; $display("FAIL stall_readback: got %h,%h want 55,66", r_rd[3], r_rd[4]); end
    endtask

    task automatic test_reset_mid_read;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 5'd0; bus.req_len = 5'd7;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL rst_pre_read k=%0d: got %b want 1", k, bus.mem_read); end
        end
        @(posedge clk); #1;
        rst_ = 1'b0;
        #1;
        n_cmp++; if ({bus.mem_read, bus.mem_write, bus.mem_addr} !== 7'h0) begin n_err++; $display("FAIL rst_async_strobes: got rd=%b wr=%b a=%0d want 0", bus.mem_read, bus.mem_write, bus.mem_addr); end
        n_cmp++; if ({bus.req_ready, bus.rsp_valid, bus.done} !== 3'b100) begin n_err++; $display("FAIL rst_async_flags: got ready,rv,done=%b want 100", {bus.req_ready, bus.rsp_valid, bus.done}); end
        repeat (2) begin
            @(negedge clk);
            n_cmp++; if ({bus.rsp_valid, bus.done} !== 2'b00) begin n_err++; $display("FAIL rst_hold: got rv,done=%b want 00", {bus.rsp_valid, bus.done}); end
        end
        @(posedge clk); #1;
        rst_ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if ({bus.req_ready, bus.rsp_valid, bus.done, bus.mem_read} !== 4'b1000) begin n_err++; $display("FAIL rst_after k=%0d: got ready,rv,done,rd=%b want 1000", k, {bus.req_ready, bus.rsp_valid, bus.done, bus.mem_read}); end
        end
        run_read(5'd10, 5'd0, 5);
        n_cmp++; if ({r_mrd[1], r_rv[3], r_rd[3], r_rl[3], r_dn[3], r_rr[4]} !== {1'b1, 1'b1, fmem(10), 1'b1, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL rst_new_burst: got rd=%b v=%b d=%h l=%b done=%b ready=%b want 1 1 %h 1 1 1", r_mrd[1], r_rv[3], r_rd[3], r_rl[3], r_dn[3], r_rr[4], fmem(10));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) mem[i] = fmem(i);
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.wdata_valid = 1'b0; bus.wdata = '0;
        test_reset;
        test_full_burst;
        test_read_latency;
        test_write_burst;
        test_wrap;
        test_write_stall;
        test_reset_mid_read;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
